// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN feature-map datapath.
//   POOL_AVG / POOL_MAX : pooling-mode encodings for pooling_2d.POOL_MODE
//   clog2()             : ceiling log2, usable in parameter expressions
//   pool_params_ok()    : legality check for pooling_2d parameters, evaluated
//                         at elaboration by the pooling stage
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int POOL_AVG = 0;
    localparam int POOL_MAX = 1;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Window must be 2 or 4, stride 1..K, frame at least one window in size.
    function automatic bit pool_params_ok(input int k, input int s,
                                          input int w, input int h);
        return ((k == 2) || (k == 4)) && (s >= 1) && (s <= k) &&
               (w >= k) && (h >= k);
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// -----------------------------------------------------------------------------
// pool_line_buffer
// Chain of DEPTH_ROWS row-delay lines, each INPUT_WIDTH samples deep, built
// as shift registers that advance only when ce is high.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears every stored sample
//   ce    : shift enable (one accepted sample)
//   din   : incoming sample of the current row
//   taps  : flattened outputs; slice j holds the same column from row r-1-j
// -----------------------------------------------------------------------------
module pool_line_buffer #(
    parameter int DATA_SIZE   = 16,
    parameter int INPUT_WIDTH = 28,
    parameter int DEPTH_ROWS  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ce,
    input  logic [DATA_SIZE-1:0]            din,
    output logic [DEPTH_ROWS*DATA_SIZE-1:0] taps
);

    logic [DATA_SIZE-1:0] line_q [DEPTH_ROWS][INPUT_WIDTH];

    // Each line is exactly one row long, so its last stage holds the sample
    // accepted INPUT_WIDTH beats ago: the same column one row earlier. The
    // last stage of line j feeds the first stage of line j+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH_ROWS; r++) begin
                for (int c = 0; c < INPUT_WIDTH; c++) begin
                    line_q[r][c] <= '0;
                end
            end
        end else if (ce) begin
            for (int r = 0; r < DEPTH_ROWS; r++) begin
                for (int c = INPUT_WIDTH - 1; c > 0; c--) begin
                    line_q[r][c] <= line_q[r][c-1];
                end
            end
            line_q[0][0] <= din;
            for (int r = 1; r < DEPTH_ROWS; r++) begin
                line_q[r][0] <= line_q[r-1][INPUT_WIDTH-1];
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH_ROWS; gi++) begin : g_taps
        assign taps[gi*DATA_SIZE +: DATA_SIZE] = line_q[gi][INPUT_WIDTH-1];
    end

endmodule

// File: rtl/pooling_2d.sv
// -----------------------------------------------------------------------------
// pooling_2d
// Streaming K x K pooling over a raster-ordered frame (average or max).
//   clk         : clock, all state on rising edge
//   rst_n       : asynchronous active-low reset
//   input_data  : signed sample, qualified by input_valid
//   input_valid : sample strobe; gaps are allowed
//   out_data    : signed pooled result, 0 whenever out_valid is low
//   out_valid   : one-cycle pulse per completed window, 2 cycles after the
//                 completing sample
//   frame_done  : one-cycle pulse alongside the last out_valid of a frame
// -----------------------------------------------------------------------------
module pooling_2d
    import cnn_pkg::*;
#(
    parameter int INPUT_WIDTH  = 28,
    parameter int INPUT_HEIGHT = 28,
    parameter int WINDOW_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int DATA_SIZE    = 16,
    parameter int POOL_MODE    = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [DATA_SIZE-1:0] input_data,
    input  logic                        input_valid,
    output logic signed [DATA_SIZE-1:0] out_data,
    output logic                        out_valid,
    output logic                        frame_done
);

    localparam int K  = WINDOW_SIZE;
    localparam int CW = clog2(INPUT_WIDTH);
    localparam int RW = clog2(INPUT_HEIGHT);
    // Position of the final window of a frame; trailing rows/columns that
    // cannot fill a window never fire.
    localparam int LAST_ROW = INPUT_HEIGHT - 1 - ((INPUT_HEIGHT - K) % STRIDE);
    localparam int LAST_COL = INPUT_WIDTH - 1 - ((INPUT_WIDTH - K) % STRIDE);

    if (!pool_params_ok(WINDOW_SIZE, STRIDE, INPUT_WIDTH, INPUT_HEIGHT)) begin : g_param_error
        $error("pooling_2d: illegal WINDOW_SIZE/STRIDE/INPUT_WIDTH/INPUT_HEIGHT");
    end

    // ---------------------------------------------------------------- counters
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (input_valid) begin
            if (col_q == CW'(INPUT_WIDTH - 1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(INPUT_HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ line buffer
    logic [(K-1)*DATA_SIZE-1:0] taps;

    pool_line_buffer #(
        .DATA_SIZE   (DATA_SIZE),
        .INPUT_WIDTH (INPUT_WIDTH),
        .DEPTH_ROWS  (K - 1)
    ) u_line_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (input_valid),
        .din   (input_data),
        .taps  (taps)
    );

    // ---------------------------------------------------------- window register
    // win_q[row][col]: row K-1 is the current input row, row 0 the oldest;
    // col K-1 is the newest column.
    logic signed [DATA_SIZE-1:0] win_q   [K][K];
    logic signed [DATA_SIZE-1:0] new_col [K];

    assign new_col[K-1] = input_data;
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_new_col
        assign new_col[K-2-gi] = $signed(taps[gi*DATA_SIZE +: DATA_SIZE]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else if (input_valid) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_q[i][j] <= win_q[i][j+1];
                end
                win_q[i][K-1] <= new_col[i];
            end
        end
    end

    // ----------------------------------------------------- window-complete test
    int   row_int;
    int   col_int;
    logic fire_d;
    logic last_d;

    always_comb begin
        row_int = int'(row_q);
        col_int = int'(col_q);
        fire_d  = input_valid &&
                  (row_int >= K - 1) && (col_int >= K - 1) &&
                  (((row_int - (K - 1)) % STRIDE) == 0) &&
                  (((col_int - (K - 1)) % STRIDE) == 0);
        last_d  = fire_d && (row_int == LAST_ROW) && (col_int == LAST_COL);
    end

    // --------------------------------------------------------------- reduction
    logic signed [DATA_SIZE-1:0] red;

    if (POOL_MODE == POOL_MAX) begin : g_max
        always_comb begin
            red = win_q[0][0];
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    if (win_q[i][j] > red) begin
                        red = win_q[i][j];
                    end
                end
            end
        end
    end else begin : g_avg
        // K*K = 2^SHIFT samples; the widened sum cannot overflow and the
        // arithmetic shift floors toward minus infinity.
        localparam int SHIFT = 2 * clog2(K);
        localparam int SUM_W = DATA_SIZE + SHIFT;
        logic signed [SUM_W-1:0] sum;

        always_comb begin
            sum = '0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    sum = sum + SUM_W'(win_q[i][j]);
                end
            end
            red = DATA_SIZE'(sum >>> SHIFT);
        end
    end

    // ---------------------------------------------------------------- pipeline
    // fire_q/last_q mark that win_q now holds a completed window; the next
    // edge registers its reduction. Advances every cycle, so input gaps
    // cannot hold back a window that has already fired.
    logic                        fire_q;
    logic                        last_q;
    logic signed [DATA_SIZE-1:0] out_data_q;
    logic                        out_valid_q;
    logic                        frame_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_q       <= 1'b0;
            last_q       <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fire_q       <= fire_d;
            last_q       <= last_d;
            out_valid_q  <= fire_q;
            frame_done_q <= last_q;
            out_data_q   <= fire_q ? red : '0;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pooling_2d.sv
// -----------------------------------------------------------------------------
// tb_pooling_2d
// Directed bench for pooling_2d. Three instances:
//   dut_avg : 4x4, K=2, S=2, average
//   dut_max : 4x4, K=2, S=2, max      (shares stimulus with dut_avg)
//   dut_s1  : 3x3, K=2, S=1, average
// Expected results are hand-computed tables; each window's expected output
// cycle is scheduled when its completing sample is driven.
// -----------------------------------------------------------------------------
module tb_pooling_2d;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic signed [15:0] data_a, data_b;
    logic               valid_a, valid_b;

    logic signed [15:0] avg_data, max_data, s1_data;
    logic               avg_valid, max_valid, s1_valid;
    logic               avg_done, max_done, s1_done;

    pooling_2d #(.INPUT_WIDTH(4), .INPUT_HEIGHT(4), .WINDOW_SIZE(2), .STRIDE(2),
                 .DATA_SIZE(16), .POOL_MODE(0)) dut_avg (
        .clk(clk), .rst_n(rst_n), .input_data(data_a), .input_valid(valid_a),
        .out_data(avg_data), .out_valid(avg_valid), .frame_done(avg_done));

    pooling_2d #(.INPUT_WIDTH(4), .INPUT_HEIGHT(4), .WINDOW_SIZE(2), .STRIDE(2),
                 .DATA_SIZE(16), .POOL_MODE(1)) dut_max (
        .clk(clk), .rst_n(rst_n), .input_data(data_a), .input_valid(valid_a),
        .out_data(max_data), .out_valid(max_valid), .frame_done(max_done));

    pooling_2d #(.INPUT_WIDTH(3), .INPUT_HEIGHT(3), .WINDOW_SIZE(2), .STRIDE(1),
                 .DATA_SIZE(16), .POOL_MODE(0)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .input_data(data_b), .input_valid(valid_b),
        .out_data(s1_data), .out_valid(s1_valid), .frame_done(s1_done));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int avg;
        int mx;
        bit done;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Stream A bookkeeping (4x4, windows complete at odd row & odd column)
    int row_a = 0, col_a = 0, idx_a = 0;
    int exp_avg_a[4];
    int exp_max_a[4];
    // Stream B bookkeeping (3x3, windows complete at row>=1 & col>=1)
    int row_b = 0, col_b = 0, idx_b = 0;
    int exp_avg_b[4] = '{2, 3, 5, 6};

    // ---------------------------------------------------------------- monitors
    always @(negedge clk) begin
        if (rst_n) begin
            while (qa.size() > 0 && qa[0].cyc < cyc) begin
                check_eq("a_missing_out_cycle", cyc, qa[0].cyc);
                void'(qa.pop_front());
            end
            if (avg_valid || max_valid) begin
                if (qa.size() == 0) begin
                    check_eq("a_unexpected_out", qa.size(), 1);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    $display("[TB] A out cyc=%0d avg=%0d max=%0d done=%0d/%0d",
                             cyc, avg_data, max_data, avg_done, max_done);
                    check_eq("a_latency", cyc, e.cyc);
                    check_eq("a_avg_valid", avg_valid, 1);
                    check_eq("a_max_valid", max_valid, 1);
                    check_eq("a_avg_data", avg_data, e.avg);
                    check_eq("a_max_data", max_data, e.mx);
                    check_eq("a_avg_done", avg_done, e.done);
                    check_eq("a_max_done", max_done, e.done);
                end
            end else begin
                check_eq("a_idle_zero", longint'({avg_data, max_data, avg_done, max_done}), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            while (qb.size() > 0 && qb[0].cyc < cyc) begin
                check_eq("b_missing_out_cycle", cyc, qb[0].cyc);
                void'(qb.pop_front());
            end
            if (s1_valid) begin
                if (qb.size() == 0) begin
                    check_eq("b_unexpected_out", qb.size(), 1);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    $display("[TB] B out cyc=%0d avg=%0d done=%0d", cyc, s1_data, s1_done);
                    check_eq("b_latency", cyc, e.cyc);
                    check_eq("b_data", s1_data, e.avg);
                    check_eq("b_done", s1_done, e.done);
                end
            end else begin
                check_eq("b_idle_zero", longint'({s1_data, s1_done}), 0);
            end
        end
    end

    // ----------------------------------------------------------------- drivers
    task automatic drive_a(input int d, input int gap);
        repeat (gap) begin
            @(negedge clk);
            valid_a = 1'b0;
        end
        @(negedge clk);
        data_a  = 16'(d);
        valid_a = 1'b1;
        if ((row_a % 2 == 1) && (col_a % 2 == 1)) begin
            exp_t e;
            e.cyc  = cyc + 2;
            e.avg  = exp_avg_a[idx_a];
            e.mx   = exp_max_a[idx_a];
            e.done = (idx_a == 3);
            qa.push_back(e);
            idx_a++;
        end
        col_a++;
        if (col_a == 4) begin
            col_a = 0;
            row_a = (row_a + 1) % 4;
            if (row_a == 0) idx_a = 0;
        end
    endtask

    task automatic drive_b(input int d, input int gap);
        repeat (gap) begin
            @(negedge clk);
            valid_b = 1'b0;
        end
        @(negedge clk);
        data_b  = 16'(d);
        valid_b = 1'b1;
        if (row_b >= 1 && col_b >= 1) begin
            exp_t e;
            e.cyc  = cyc + 2;
            e.avg  = exp_avg_b[idx_b];
            e.mx   = 0;
            e.done = (idx_b == 3);
            qb.push_back(e);
            idx_b++;
        end
        col_b++;
        if (col_b == 3) begin
            col_b = 0;
            row_b = (row_b + 1) % 3;
            if (row_b == 0) idx_b = 0;
        end
    endtask

    task automatic set_exp_a(input int a0, input int a1, input int a2, input int a3,
                             input int m0, input int m1, input int m2, input int m3);
        exp_avg_a = '{a0, a1, a2, a3};
        exp_max_a = '{m0, m1, m2, m3};
    endtask

    // kind 0: ramp 0..15, kind 1: all -1, kind 2: -3 at (0,0) and zeros
    function automatic int sample_a(input int kind, input int i);
        if (kind == 0) return i;
        if (kind == 1) return -1;
        return (i == 0) ? -3 : 0;
    endfunction

    task automatic frame_a(input int kind, input int gap_max, input int count);
        for (int i = 0; i < count; i++) begin
            drive_a(sample_a(kind, i), (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    task automatic drain_a();
        repeat (6) @(negedge clk);
        check_eq("a_pending_after_frame", qa.size(), 0);
    endtask

    task automatic frame_b(input int gap_max);
        for (int i = 0; i < 9; i++) begin
            drive_b(i, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        @(negedge clk);
        valid_b = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("b_pending_after_frame", qb.size(), 0);
    endtask

    task automatic check_all_clear(input string tag);
        check_eq({tag, "_avg"}, longint'({avg_data, avg_valid, avg_done}), 0);
        check_eq({tag, "_max"}, longint'({max_data, max_valid, max_done}), 0);
        check_eq({tag, "_s1"},  longint'({s1_data, s1_valid, s1_done}), 0);
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        rst_n   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        #2 rst_n = 1'b0;
        #1 check_all_clear("reset_state");
        repeat (3) @(negedge clk);
        check_all_clear("reset_held");
        rst_n = 1'b1;

        // Ramp, average 2,4,10,12 / max 5,7,13,15
        set_exp_a(2, 4, 10, 12, 5, 7, 13, 15);
        frame_a(0, 0, 16);
        drain_a();

        // All -1: floor(-4/4) = -1
        set_exp_a(-1, -1, -1, -1, -1, -1, -1, -1);
        frame_a(1, 0, 16);
        drain_a();

        // {-3,0,0,0}: floor(-3/4) = -1
        set_exp_a(-1, 0, 0, 0, 0, 0, 0, 0);
        frame_a(2, 0, 16);
        drain_a();

        // Ramp with random input gaps
        set_exp_a(2, 4, 10, 12, 5, 7, 13, 15);
        frame_a(0, 3, 16);
        drain_a();

        // 3x3 stride-1 frame, back-to-back then with gaps
        frame_b(0);
        frame_b(2);

        // 7 samples, then asynchronous reset mid-frame
        set_exp_a(2, 4, 10, 12, 5, 7, 13, 15);
        frame_a(0, 0, 7);
        #1 rst_n = 1'b0;
        #1 check_all_clear("reset_async");
        check_eq("a_pending_at_reset", qa.size(), 0);
        qa.delete();
        row_a = 0;
        col_a = 0;
        idx_a = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame_a(0, 0, 16);
        drain_a();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pooling_2d.md
# pooling_2d

Streaming 2-D pooling stage for the CNN feature-map datapath.
- Accepts one raster-ordered sample per `input_valid` beat and keeps K−1 rows in internal line buffers.
- Emits one pooled result per completed K×K window, using either average or max selected by parameter.
- Generalises the fixed 2×2 average pooler: window size, stride, frame width/height and pooling mode are all configurable.
- Adds a per-frame completion pulse.

## Interface
Parameters:
- `INPUT_WIDTH`, 28: samples per row (≥ WINDOW_SIZE).
- `INPUT_HEIGHT`, 28: rows per frame (≥ WINDOW_SIZE).
- `WINDOW_SIZE`, 2: K. Legal values are 2 or 4 only.
- `STRIDE`, 2: S, in the range 1..K.
- `DATA_SIZE`, 16: signed sample width.
- `POOL_MODE`, 0: 0 selects average, 1 selects max.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `input_data` input DATA_SIZE: signed sample.
- `input_valid` input 1: sample qualifier; may be deasserted any cycle (gaps allowed).
- `out_data` output DATA_SIZE: signed pooled result; 0 when `out_valid` low.
- `out_valid` output 1: single-cycle pulse per window.
- `frame_done` output 1: single-cycle pulse, coincident with the last `out_valid` of a frame.

## Operation
- Counters `col` (0..W−1) and `row` (0..H−1) advance only on `input_valid`.
  - `col` wraps at W−1 and increments `row`.
  - `row` wraps at H−1 back to 0, so the next valid sample is (0,0) of a new frame.
- Line buffer: K−1 row-delay lines of depth W, shifted on `input_valid` only.
  - Taps give column c of rows r−1..r−K+1.
- Window register: K×K array.
  - On each valid beat the array shifts one column left.
  - The new rightmost column is {line taps, `input_data`}.
- Window-complete condition, evaluated on the valid beat at (r,c):
  - r ≥ K−1 and c ≥ K−1,
  - (r−K+1) mod S = 0,
  - (c−K+1) mod S = 0.
- Outputs per frame: ((W−K)/S+1) × ((H−K)/S+1), floor division. Trailing columns/rows that cannot fill a window are consumed and produce nothing.
- Average mode:
  - Sum all K² samples at width DATA_SIZE+2·log2(K), sign-extended; no overflow possible.
  - Result is the sum arithmetic-shifted right by 2·log2(K) (floor toward −∞), truncated to DATA_SIZE. The result is always in range.
- Max mode: signed comparison tree over the K² samples.
- Window columns from a previous row are never mixed: a window fires only when c ≥ K−1, so the stale left columns have already been flushed.

## Timing
- Reset values: `out_data` 0, `out_valid` 0, `frame_done` 0. Counters, window register and line buffers also reset to 0.
- Latency is 2 cycles from the completing valid beat to `out_valid`:
  - Cycle 0: sample accepted; window register updated; a `fire` flag is registered.
  - Cycle 1: reduction is computed from the window register and registered.
  - Cycle 2: `out_valid`=1 with `out_data`.
- The pipeline advances every cycle regardless of `input_valid`. Back-to-back completing beats give back-to-back `out_valid` pulses.
- `frame_done` asserts with the `out_valid` of the window completed at (H−1 − ((H−K) mod S), last firing column). It is registered alongside `fire`.
- An input gap never suppresses or delays an already-fired window.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronous).
  - Any in-flight result is discarded.
  - After release, the first valid beat is position (0,0).
- With S=1, a window fires on every valid beat where r,c ≥ K−1.

## Structure
- Shared package `cnn_pkg`:
  - `POOL_AVG`=0, `POOL_MAX`=1.
  - `clog2` function.
  - Elaboration checks: K ∈ {2,4}, 1 ≤ S ≤ K, W,H ≥ K.
- Sub-module `pool_line_buffer`:
  - Parameters DATA_SIZE, INPUT_WIDTH, DEPTH_ROWS=K−1.
  - Ports `clk`, `rst_n`, `ce`, `din`, and flattened tap output.
  - Implemented as shift registers or RAM plus a pointer.
- Top-level `pooling_2d` holds:
  - counters,
  - window register,
  - fire/frame_done pipeline,
  - mode-specific reduction, selected by generate on POOL_MODE.

## Test plan
- 4×4 frame, values 0..15, K=2, S=2, avg → outputs 2, 4, 10, 12; `frame_done` on the 4th output.
- Same frame with POOL_MODE=1 → outputs 5, 7, 13, 15.
- 3×3 frame, values 0..8, K=2, S=1, avg → outputs 2, 3, 5, 6.
- All samples −1, or window {−3, 0, 0, 0}, avg K=2 → −1 in both cases (floor toward −∞).
- 4×4 frame, values 0..15, K=2, S=2, with random `input_valid` gaps → same 2, 4, 10, 12. Each output arrives exactly 2 cycles after its completing beat.
- Reset pulse after 7 samples, then a full fresh 4×4 frame → no spurious output; results 2, 4, 10, 12.
